psr_cc_unit: RTL and testbench

- Processor Status Register and condition-code stage of the LC-3 datapath.
- Directly upstream of the branch-enable register. It sets NZP from the bus and drives the 3-bit NZP that the branch-enable logic ANDs with IR[11:9].
- Also holds the privilege bit, the priority level and a shadow PSR for interrupt entry and RTI.
- Qualifies external interrupt requests against the current priority and raises a pending flag for the control unit.

---
 rtl/psr_cc_unit_if.sv | 28 ++
 rtl/psr_cc_unit.sv | 135 +++++++++++++
 tb/tb_psr_cc_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/psr_cc_unit_if.sv
// Handshake/bus bundle for the LC-3 PSR / condition-code stage.
// The master modport is the control side and the slave modport is the PSR unit.
interface psr_cc_unit_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] Bus_in;
  logic             LD_CC;
  logic             LD_PSR;
  logic             GatePSR;
  logic             Irq_req;
  logic [2:0]       Irq_pri;
  logic             Irq_ack;
  logic             RTI_restore;
  logic [2:0]       NZP;
  logic             Priv;
  logic [2:0]       Pri;
  logic [WIDTH-1:0] PSR_out;
  logic             Irq_pending;
  logic             Priv_violation;

  modport master (
    output Bus_in, LD_CC, LD_PSR, GatePSR, Irq_req, Irq_pri, Irq_ack, RTI_restore,
    input  NZP, Priv, Pri, PSR_out, Irq_pending, Priv_violation
  );

  modport slave (
    input  Bus_in, LD_CC, LD_PSR, GatePSR, Irq_req, Irq_pri, Irq_ack, RTI_restore,
    output NZP, Priv, Pri, PSR_out, Irq_pending, Priv_violation
  );
endinterface

// File: rtl/psr_cc_unit.sv
// LC-3 Processor Status Register: NZP condition codes, privilege, priority,
// one-level shadow PSR for interrupt entry / RTI, and interrupt qualification.
module psr_cc_unit #(
  parameter int WIDTH = 16
) (
  input logic          Clk,
  input logic          Reset,
  psr_cc_unit_if.slave bus
);

  logic [2:0]       r_nzp;
  logic             r_priv;
  logic [2:0]       r_pri;
  logic             r_sh_priv;
  logic [2:0]       r_sh_pri;
  logic [2:0]       r_sh_nzp;
  logic             r_irq_pending;
  logic [2:0]       r_pend_pri;
  logic             r_priv_viol;

  logic [2:0]       w_nzp_nxt;
  logic             w_priv_nxt;
  logic [2:0]       w_pri_nxt;
  logic             w_sh_priv_nxt;
  logic [2:0]       w_sh_pri_nxt;
  logic [2:0]       w_sh_nzp_nxt;
  logic             w_irq_pending_nxt;
  logic [2:0]       w_pend_pri_nxt;
  logic             w_priv_viol_nxt;
  logic             w_take_irq;
  logic [WIDTH-1:0] w_psr_img;

  function automatic logic [2:0] cc_from_bus(input logic [WIDTH-1:0] value);
    if (value[WIDTH-1]) begin
      return 3'b100;
    end else if (value == {WIDTH{1'b0}}) begin
      return 3'b010;
    end else begin
      return 3'b001;
    end
  endfunction

  // PSR image {Priv, 4'b0, Pri, 5'b0, NZP}
  always_comb begin
    w_psr_img              = {WIDTH{1'b0}};
    w_psr_img[WIDTH-1]     = r_priv;
    w_psr_img[10:8]        = r_pri;
    w_psr_img[2:0]         = r_nzp;
  end

  // Next-state: ack > RTI > LD_PSR > LD_CC, plus interrupt qualification
  always_comb begin
    w_nzp_nxt         = r_nzp;
    w_priv_nxt        = r_priv;
    w_pri_nxt         = r_pri;
    w_sh_priv_nxt     = r_sh_priv;
    w_sh_pri_nxt      = r_sh_pri;
    w_sh_nzp_nxt      = r_sh_nzp;
    w_irq_pending_nxt = r_irq_pending;
    w_pend_pri_nxt    = r_pend_pri;
    w_priv_viol_nxt   = 1'b0;
    w_take_irq        = bus.Irq_ack & r_irq_pending;

    if (bus.Irq_ack) begin
      if (r_irq_pending) begin
        w_sh_priv_nxt     = r_priv;
        w_sh_pri_nxt      = r_pri;
        w_sh_nzp_nxt      = r_nzp;
        w_priv_nxt        = 1'b0;
        w_pri_nxt         = r_pend_pri;
        w_irq_pending_nxt = 1'b0;
        w_pend_pri_nxt    = 3'd0;
      end else begin
        w_priv_viol_nxt   = 1'b0;
      end
    end else if (bus.RTI_restore) begin
      if (!r_priv) begin
        w_priv_nxt = r_sh_priv;
        w_pri_nxt  = r_sh_pri;
        w_nzp_nxt  = r_sh_nzp;
      end else begin
        w_priv_viol_nxt = 1'b1;
      end
    end else if (bus.LD_PSR) begin
      w_priv_nxt = bus.Bus_in[WIDTH-1];
      w_pri_nxt  = bus.Bus_in[10:8];
      w_nzp_nxt  = bus.Bus_in[2:0];
    end else if (bus.LD_CC) begin
      w_nzp_nxt = cc_from_bus(bus.Bus_in);
    end else begin
      w_nzp_nxt = r_nzp;
    end

    // Requests coincident with an accepted ack are dropped, re-judged next cycle
    if (!w_take_irq && bus.Irq_req && (bus.Irq_pri > r_pri)) begin
      w_irq_pending_nxt = 1'b1;
      w_pend_pri_nxt    = (bus.Irq_pri > r_pend_pri) ? bus.Irq_pri : r_pend_pri;
    end else begin
      w_pend_pri_nxt    = w_pend_pri_nxt;
    end
  end

  // State registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_nzp         <= 3'b010;
      r_priv        <= 1'b0;
      r_pri         <= 3'd0;
      r_sh_priv     <= 1'b0;
      r_sh_pri      <= 3'd0;
      r_sh_nzp      <= 3'b010;
      r_irq_pending <= 1'b0;
      r_pend_pri    <= 3'd0;
      r_priv_viol   <= 1'b0;
    end else begin
      r_nzp         <= w_nzp_nxt;
      r_priv        <= w_priv_nxt;
      r_pri         <= w_pri_nxt;
      r_sh_priv     <= w_sh_priv_nxt;
      r_sh_pri      <= w_sh_pri_nxt;
      r_sh_nzp      <= w_sh_nzp_nxt;
      r_irq_pending <= w_irq_pending_nxt;
      r_pend_pri    <= w_pend_pri_nxt;
      r_priv_viol   <= w_priv_viol_nxt;
    end
  end

  assign bus.NZP            = r_nzp;
  assign bus.Priv           = r_priv;
  assign bus.Pri            = r_pri;
  assign bus.Irq_pending    = r_irq_pending;
  assign bus.Priv_violation = r_priv_viol;
  assign bus.PSR_out        = bus.GatePSR ? w_psr_img : {WIDTH{1'b0}};

endmodule

// File: tb/tb_psr_cc_unit.sv
// Self-checking bench for psr_cc_unit: a spec-level model pushes expected
// post-edge state into a scoreboard queue, popped and compared after each edge.
module tb_psr_cc_unit;
  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  psr_cc_unit_if #(.WIDTH(16)) bus_if ();

  psr_cc_unit #(.WIDTH(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  nzp;
    logic        priv;
    logic [2:0]  pri;
    logic        pend;
    logic        viol;
    logic [15:0] psr;
  } exp_t;

  exp_t sb_q[$];

  // reference model state
  logic [2:0]  m_nzp, m_pri, m_ppri;
  logic        m_priv, m_pend, m_viol;
  logic [15:0] m_shadow;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_nzp = 3'b010; m_priv = 1'b0; m_pri = 3'd0; m_shadow = 16'h0002;
    m_pend = 1'b0; m_ppri = 3'd0; m_viol = 1'b0;
  endtask

  function automatic logic [15:0] img(input logic pv, input logic [2:0] pr, input logic [2:0] cc);
    return {pv, 4'b0000, pr, 5'b00000, cc};
  endfunction

  // Drive one cycle, push expected post-edge outputs, then compare after the edge
  task automatic step(input string tag, input logic [15:0] bus, input logic ldcc,
                      input logic ldpsr, input logic gate, input logic req,
                      input logic [2:0] ipri, input logic ack, input logic rti);
    exp_t e;
    logic take;
    logic [2:0] n_nzp, n_pri, n_ppri;
    logic n_priv, n_pend;
    logic [15:0] n_shadow;
    bus_if.Bus_in = bus; bus_if.LD_CC = ldcc; bus_if.LD_PSR = ldpsr;
    bus_if.GatePSR = gate; bus_if.Irq_req = req; bus_if.Irq_pri = ipri;
    bus_if.Irq_ack = ack; bus_if.RTI_restore = rti;

    n_nzp = m_nzp; n_pri = m_pri; n_ppri = m_ppri; n_priv = m_priv;
    n_pend = m_pend; n_shadow = m_shadow; m_viol = 1'b0;
    take = ack && m_pend;
    if (ack) begin
      if (m_pend) begin
        n_shadow = img(m_priv, m_pri, m_nzp);
        n_priv = 1'b0; n_pri = m_ppri; n_pend = 1'b0; n_ppri = 3'd0;
      end
    end else if (rti) begin
      if (!m_priv) begin
        n_priv = m_shadow[15]; n_pri = m_shadow[10:8]; n_nzp = m_shadow[2:0];
      end else begin
        m_viol = 1'b1;
      end
    end else if (ldpsr) begin
      n_priv = bus[15]; n_pri = bus[10:8]; n_nzp = bus[2:0];
    end else if (ldcc) begin
      n_nzp = bus[15] ? 3'b100 : ((bus == 16'h0000) ? 3'b010 : 3'b001);
    end
    if (!take && req && (ipri > m_pri)) begin
      n_pend = 1'b1;
      n_ppri = (ipri > m_ppri) ? ipri : m_ppri;
    end
    m_nzp = n_nzp; m_pri = n_pri; m_ppri = n_ppri; m_priv = n_priv;
    m_pend = n_pend; m_shadow = n_shadow;

    e.nzp = m_nzp; e.priv = m_priv; e.pri = m_pri; e.pend = m_pend; e.viol = m_viol;
    e.psr = gate ? img(m_priv, m_pri, m_nzp) : 16'h0000;
    sb_q.push_back(e);

    @(posedge Clk);
    #1;
    check_val({tag, ".sb_size"}, sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, ".nzp"},  {29'd0, bus_if.NZP},            {29'd0, e.nzp});
      check_val({tag, ".priv"}, {31'd0, bus_if.Priv},           {31'd0, e.priv});
      check_val({tag, ".pri"},  {29'd0, bus_if.Pri},            {29'd0, e.pri});
      check_val({tag, ".pend"}, {31'd0, bus_if.Irq_pending},    {31'd0, e.pend});
      check_val({tag, ".viol"}, {31'd0, bus_if.Priv_violation}, {31'd0, e.viol});
      check_val({tag, ".psr"},  {16'd0, bus_if.PSR_out},        {16'd0, e.psr});
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    Reset = 1'b0;
    bus_if.Bus_in = 16'h0000; bus_if.LD_CC = 1'b0; bus_if.LD_PSR = 1'b0;
    bus_if.GatePSR = 1'b0; bus_if.Irq_req = 1'b0; bus_if.Irq_pri = 3'd0;
    bus_if.Irq_ack = 1'b0; bus_if.RTI_restore = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;

    // Mid-operation reset: state must clear asynchronously
    step("pre_rst_psr", 16'hC703, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
    bus_if.LD_CC = 1'b1; bus_if.Bus_in = 16'h8000;
    #2 Reset = 1'b0;
    #1;
    check_val("async_rst.nzp",  {29'd0, bus_if.NZP},         32'd2);
    check_val("async_rst.priv", {31'd0, bus_if.Priv},        32'd0);
    check_val("async_rst.pend", {31'd0, bus_if.Irq_pending}, 32'd0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    model_reset();
    idle("rst_state");
    check_val("rst_psr_const", {16'd0, bus_if.PSR_out}, 32'h0002);

    step("ldcc_neg",  16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check_val("ldcc_neg_const", {29'd0, bus_if.NZP}, 32'd4);
    step("ldcc_zero", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check_val("ldcc_zero_const", {29'd0, bus_if.NZP}, 32'd2);
    step("ldcc_pos",  16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check_val("ldcc_pos_const", {29'd0, bus_if.NZP}, 32'd1);

    step("ldpsr_ldcc", 16'h8305, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check_val("ldpsr_const", {16'd0, bus_if.PSR_out}, 32'h8305);

    step("irq_eq_pri", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    check_val("irq_eq_const", {31'd0, bus_if.Irq_pending}, 32'd0);
    step("irq_pri5",   16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    idle("irq_held");
    check_val("irq_held_const", {31'd0, bus_if.Irq_pending}, 32'd1);
    step("irq_ack",    16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    check_val("irq_ack_const", {16'd0, bus_if.PSR_out}, 32'h0505);

    step("rti_sup",  16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    check_val("rti_const", {16'd0, bus_if.PSR_out}, 32'h8305);
    step("rti_user", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    check_val("rti_viol_const", {31'd0, bus_if.Priv_violation}, 32'd1);
    idle("viol_drop");

    step("irq_pri6",  16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
    step("ack_vs_rti", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    check_val("ack_wins_const", {29'd0, bus_if.Pri}, 32'd6);
    step("ack_nopend", 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    step("rti_back",   16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

    // Randomised traffic, occasional pulses so every control gets exercised
    for (int i = 0; i < 300; i++) begin
      logic [15:0] rb;
      rb = 16'($urandom);
      step("rand", rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 6) == 0));
    end

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
